// File: rtl/id_stage_pipe.sv
// Decode stage between IF and EX: decodes one instruction per cycle into the ID/EX register.
// Optional load-use interlock enabled by defining ID_LOADUSE_INTERLOCK_EN.
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  output logic              id_ready,
  input  logic              ex_stall,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  input  logic [DATA_W-1:0] rs1_data_in,
  input  logic [DATA_W-1:0] rs2_data_in,
  output logic              branch_taken,
  output logic [5:0]        branch_offset_imm,
  output logic              id_ex_valid,
  output logic [2:0]        alu_cmd,
  output logic [DATA_W-1:0] rs1_data_out,
  output logic [DATA_W-1:0] rs2_data_out,
  output logic [DATA_W-1:0] id_ex_store_data,
  output logic [2:0]        id_ex_op_dest,
  output logic              id_ex_mem_write_en,
  output logic              id_ex_wb_mux,
  output logic              id_ex_wb_en,
  output logic              illegal_instr,
  output logic [STAT_W-1:0] stall_count
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [5:0] imm);
    return {{(DATA_W-6){imm[5]}}, imm};
  endfunction

  logic [3:0]        opcode_s;
  logic              is_illegal_s;
  logic              hazard_s;
  logic              fire_s;
  logic              nxt_valid_s;
  logic [2:0]        nxt_cmd_s;
  logic [2:0]        nxt_dest_s;
  logic [DATA_W-1:0] nxt_a_s;
  logic [DATA_W-1:0] nxt_b_s;
  logic [DATA_W-1:0] nxt_sd_s;
  logic              nxt_mw_s;
  logic              nxt_mux_s;
  logic              nxt_wb_s;

  assign opcode_s          = if_instr[15:12];
  assign is_illegal_s      = (opcode_s >= 4'd13);
  assign rs1_addr          = if_instr[8:6];
  // ST reads its store-data register from the dest field
  assign rs2_addr          = (opcode_s == OP_ST) ? if_instr[11:9] : if_instr[5:3];
  assign branch_offset_imm = if_instr[5:0];

`ifdef ID_LOADUSE_INTERLOCK_EN
  logic reads_rs1_s;
  logic reads_rs2_s;
  assign reads_rs1_s = (opcode_s != OP_NOP);
  assign reads_rs2_s = ((opcode_s >= 4'd1) && (opcode_s <= 4'd8)) || (opcode_s == OP_ST);
  assign hazard_s = id_ex_valid && id_ex_wb_mux && if_valid &&
                    ((reads_rs1_s && (rs1_addr == id_ex_op_dest)) ||
                     (reads_rs2_s && (rs2_addr == id_ex_op_dest)));
`else
  assign hazard_s = 1'b0;
`endif

  assign id_ready     = !ex_stall && !hazard_s;
  assign fire_s       = if_valid && id_ready;
  assign branch_taken = fire_s && (opcode_s == OP_BZ) && (rs1_data_in == {DATA_W{1'b0}});

  // Decode the incoming instruction into next ID/EX contents; anything not fired is a bubble
  always_comb begin
    nxt_valid_s = 1'b0;
    nxt_cmd_s   = 3'd0;
    nxt_dest_s  = 3'd0;
    nxt_a_s     = {DATA_W{1'b0}};
    nxt_b_s     = {DATA_W{1'b0}};
    nxt_sd_s    = {DATA_W{1'b0}};
    nxt_mw_s    = 1'b0;
    nxt_mux_s   = 1'b0;
    nxt_wb_s    = 1'b0;
    if (fire_s) begin
      case (opcode_s)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          nxt_valid_s = 1'b1;
          nxt_cmd_s   = 3'(opcode_s - 4'd1);
          nxt_dest_s  = if_instr[11:9];
          nxt_a_s     = rs1_data_in;
          nxt_b_s     = rs2_data_in;
          nxt_wb_s    = 1'b1;
        end
        OP_ADDI, OP_LD: begin
          nxt_valid_s = 1'b1;
          nxt_dest_s  = if_instr[11:9];
          nxt_a_s     = rs1_data_in;
          nxt_b_s     = sext_imm(if_instr[5:0]);
          nxt_mux_s   = (opcode_s == OP_LD);
          nxt_wb_s    = 1'b1;
        end
        OP_ST: begin
          nxt_valid_s = 1'b1;
          nxt_a_s     = rs1_data_in;
          nxt_b_s     = sext_imm(if_instr[5:0]);
          nxt_sd_s    = rs2_data_in;
          nxt_mw_s    = 1'b1;
        end
        default: begin
          nxt_valid_s = 1'b0;
        end
      endcase
    end else begin
      nxt_valid_s = 1'b0;
    end
  end

  // ID/EX register with EX hold, sticky illegal flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_ex_valid        <= 1'b0;
      alu_cmd            <= 3'd0;
      id_ex_op_dest      <= 3'd0;
      rs1_data_out       <= {DATA_W{1'b0}};
      rs2_data_out       <= {DATA_W{1'b0}};
      id_ex_store_data   <= {DATA_W{1'b0}};
      id_ex_mem_write_en <= 1'b0;
      id_ex_wb_mux       <= 1'b0;
      id_ex_wb_en        <= 1'b0;
      illegal_instr      <= 1'b0;
      stall_count        <= {STAT_W{1'b0}};
    end else begin
      if (!ex_stall) begin
        id_ex_valid        <= nxt_valid_s;
        alu_cmd            <= nxt_cmd_s;
        id_ex_op_dest      <= nxt_dest_s;
        rs1_data_out       <= nxt_a_s;
        rs2_data_out       <= nxt_b_s;
        id_ex_store_data   <= nxt_sd_s;
        id_ex_mem_write_en <= nxt_mw_s;
        id_ex_wb_mux       <= nxt_mux_s;
        id_ex_wb_en        <= nxt_wb_s;
      end
      if (fire_s && is_illegal_s) begin
        illegal_instr <= 1'b1;
      end
      if (if_valid && !id_ready && (stall_count != {STAT_W{1'b1}})) begin
        stall_count <= stall_count + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed table, hand sequences and random stimulus vs a reference model.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, ex_stall;
  logic [15:0] if_instr, r1, r2;
  logic [31:0] r1_w, r2_w;
  assign r1_w = {16'h0, r1};
  assign r2_w = {16'h0, r2};

  logic        rdy, bt, v, mw, mux, wb, ill;
  logic [2:0]  ra1, ra2, cmd, dest;
  logic [5:0]  off;
  logic [15:0] a, b, sd, cnt;

  logic        rdy_w, bt_w, v_w, mw_w, mux_w, wb_w, ill_w;
  logic [2:0]  ra1_w, ra2_w, cmd_w, dest_w;
  logic [5:0]  off_w;
  logic [31:0] a_w, b_w, sd_w;
  logic [1:0]  cnt_w;

  id_stage_pipe #(.DATA_W(16), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(rdy),
    .ex_stall(ex_stall), .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data_in(r1), .rs2_data_in(r2),
    .branch_taken(bt), .branch_offset_imm(off), .id_ex_valid(v), .alu_cmd(cmd),
    .rs1_data_out(a), .rs2_data_out(b), .id_ex_store_data(sd), .id_ex_op_dest(dest),
    .id_ex_mem_write_en(mw), .id_ex_wb_mux(mux), .id_ex_wb_en(wb),
    .illegal_instr(ill), .stall_count(cnt)
  );

  id_stage_pipe #(.DATA_W(32), .STAT_W(2)) dut_w (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(rdy_w),
    .ex_stall(ex_stall), .rs1_addr(ra1_w), .rs2_addr(ra2_w), .rs1_data_in(r1_w), .rs2_data_in(r2_w),
    .branch_taken(bt_w), .branch_offset_imm(off_w), .id_ex_valid(v_w), .alu_cmd(cmd_w),
    .rs1_data_out(a_w), .rs2_data_out(b_w), .id_ex_store_data(sd_w), .id_ex_op_dest(dest_w),
    .id_ex_mem_write_en(mw_w), .id_ex_wb_mux(mux_w), .id_ex_wb_en(wb_w),
    .illegal_instr(ill_w), .stall_count(cnt_w)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  cmd;
    logic [2:0]  dest;
    logic [31:0] a, b, sd;
    logic        mw, mux, wb;
  } idex_t;

  typedef struct {
    logic        vin;
    logic [15:0] ins;
    logic        stl;
    logic [15:0] x, y;
    logic        e_rdy, e_bt, e_v;
    logic [2:0]  e_cmd, e_dest;
    logic [31:0] e_a, e_b, e_sd;
    logic        e_mw, e_mux, e_wb;
  } vec_t;

  idex_t m;
  logic  m_ill;
  int    m_cnt;
  int    n_pass = 0;
  int    n_total = 0;
  logic  got_rdy, got_bt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic reads_reg(input logic [15:0] ins, input logic [2:0] d);
    int op = int'(ins[15:12]);
    logic r = 1'b0;
    if (op != 0 && ins[8:6] == d) r = 1'b1;
    if (op >= 1 && op <= 8 && ins[5:3] == d) r = 1'b1;
    if (op == 11 && ins[11:9] == d) r = 1'b1;
    return r;
  endfunction

  // Architectural meaning of one fired instruction (32-bit view; the 16-bit DUT sees the low half)
  function automatic idex_t decode(input logic [15:0] ins, input logic [31:0] x, input logic [31:0] y);
    idex_t e = '0;
    int op = int'(ins[15:12]);
    logic [31:0] imm = 32'($signed(ins[5:0]));
    if (op >= 1 && op <= 8) begin
      e.v = 1'b1; e.cmd = 3'(op - 1); e.dest = ins[11:9]; e.a = x; e.b = y; e.wb = 1'b1;
    end else if (op == 9 || op == 10) begin
      e.v = 1'b1; e.dest = ins[11:9]; e.a = x; e.b = imm; e.wb = 1'b1; e.mux = (op == 10);
    end else if (op == 11) begin
      e.v = 1'b1; e.a = x; e.b = imm; e.sd = y; e.mw = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic rs, input logic vin, input logic [15:0] ins, input logic stl,
                      input logic [15:0] x, input logic [15:0] y);
    logic hz, e_rdy, fire, e_bt;
    logic [2:0] e_ra2;
    idex_t nm;
    int op;
    rst = rs; if_valid = vin; if_instr = ins; ex_stall = stl; r1 = x; r2 = y;
    #1;
    op = int'(ins[15:12]);
`ifdef ID_LOADUSE_INTERLOCK_EN
    hz = m.v && m.mux && vin && reads_reg(ins, m.dest);
`else
    hz = 1'b0;
`endif
    e_rdy = !stl && !hz;
    fire  = vin && e_rdy;
    e_bt  = fire && (op == 12) && (x == 16'h0);
    e_ra2 = (op == 11) ? ins[11:9] : ins[5:3];
    got_rdy = rdy;
    got_bt  = bt;
    chk("comb16", {rdy, bt, ra1, ra2, off}, {e_rdy, e_bt, ins[8:6], e_ra2, ins[5:0]});
    chk("comb32", {rdy_w, bt_w, ra1_w, ra2_w, off_w}, {e_rdy, e_bt, ins[8:6], e_ra2, ins[5:0]});
    nm = m;
    if (!stl) nm = fire ? decode(ins, {16'h0, x}, {16'h0, y}) : '0;
    @(posedge clk);
    if (!rs) begin
      m = '0; m_ill = 1'b0; m_cnt = 0;
    end else begin
      m = nm;
      if (fire && op >= 13) m_ill = 1'b1;
      if (vin && !e_rdy) m_cnt++;
    end
    #1;
    chk("ctrl16", {v, cmd, dest, mw, mux, wb}, {m.v, m.cmd, m.dest, m.mw, m.mux, m.wb});
    chk("data16", {a, b, sd}, {m.a[15:0], m.b[15:0], m.sd[15:0]});
    chk("stat16", {ill, cnt}, {m_ill, (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt)});
    chk("ctrl32", {v_w, cmd_w, dest_w, mw_w, mux_w, wb_w}, {m.v, m.cmd, m.dest, m.mw, m.mux, m.wb});
    chk("a32", a_w, m.a);
    chk("b_sd32", {b_w, sd_w}, {m.b, m.sd});
    chk("stat32", {ill_w, cnt_w}, {m_ill, (m_cnt > 3) ? 2'd3 : 2'(m_cnt)});
  endtask

  vec_t tbl[12];
  int   c0;

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = 16'h0; ex_stall = 1'b0; r1 = 16'h0; r2 = 16'h0;
    m = '0; m_ill = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state16", {v, cmd, dest, a, b, sd, mw, mux, wb, ill}, 64'h0);
    chk("reset_cnt", {cnt, cnt_w, v_w, ill_w}, 64'h0);

    tbl[0]  = '{1'b1, 16'h1650, 1'b0, 16'd5, 16'd7, 1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 16'h947F, 1'b1, 16'd9, 16'd4, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 16'h947F, 1'b0, 16'd9, 16'd4, 1'b1, 1'b0, 1'b1, 3'd0, 3'd2, 32'd9, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 16'hC085, 1'b0, 16'd0, 16'h11, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'hC085, 1'b0, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h8E50, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 3'd7, 3'd7, 32'h1234, 32'hABCD, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'hC085, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 32'h1234, 32'hABCD, 32'd0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16'hB2C3, 1'b0, 16'h0100, 16'h0055, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 32'h100, 32'h3, 32'h55, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'hA842, 1'b0, 16'h0020, 16'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd4, 32'h20, 32'h2, 32'd0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 16'h1650, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h0000, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 16'h4E3F, 1'b0, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 3'd3, 3'd7, 32'hFFFF, 32'h8000, 32'd0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].vin, tbl[i].ins, tbl[i].stl, tbl[i].x, tbl[i].y);
      chk($sformatf("tbl%0d_comb", i), {got_rdy, got_bt}, {tbl[i].e_rdy, tbl[i].e_bt});
      chk($sformatf("tbl%0d_ctrl", i), {v, cmd, dest, mw, mux, wb},
          {tbl[i].e_v, tbl[i].e_cmd, tbl[i].e_dest, tbl[i].e_mw, tbl[i].e_mux, tbl[i].e_wb});
      chk($sformatf("tbl%0d_data16", i), {a, b, sd}, {tbl[i].e_a[15:0], tbl[i].e_b[15:0], tbl[i].e_sd[15:0]});
      chk($sformatf("tbl%0d_b32", i), b_w, tbl[i].e_b);
    end

    // Load followed by a dependent ALU op
    step(1'b1, 1'b1, 16'hA842, 1'b0, 16'h30, 16'h0);
    c0 = m_cnt;
    step(1'b1, 1'b1, 16'h1B08, 1'b0, 16'h4, 16'h6);
`ifdef ID_LOADUSE_INTERLOCK_EN
    chk("lu_ready_low", got_rdy, 1'b0);
    chk("lu_bubble", v, 1'b0);
    step(1'b1, 1'b1, 16'h1B08, 1'b0, 16'h4, 16'h6);
    chk("lu_ready_high", got_rdy, 1'b1);
    chk("lu_add_fires", {v, dest, a}, {1'b1, 3'd5, 16'h4});
    chk("lu_stall_count", cnt, 16'(c0 + 1));
`else
    chk("lu_ready_high", got_rdy, 1'b1);
    chk("lu_add_fires", {v, dest, a}, {1'b1, 3'd5, 16'h4});
    chk("lu_stall_count", cnt, 16'(c0));
`endif

    // ST held behind three cycles of EX back-pressure
    step(1'b1, 1'b1, 16'h1650, 1'b0, 16'd5, 16'd7);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'hB2C3, 1'b1, 16'h40, 16'h77);
      chk("hold_ready", got_rdy, 1'b0);
      chk("hold_regs", {v, cmd, dest, a, b, wb}, {1'b1, 3'd0, 3'd3, 16'd5, 16'd7, 1'b1});
    end
    chk("hold_stall_count", cnt, 16'(c0 + 3));
    step(1'b1, 1'b1, 16'hB2C3, 1'b0, 16'h40, 16'h77);
    chk("st_release", {v, mw, wb, sd, b}, {1'b1, 1'b1, 1'b0, 16'h77, 16'h3});

    // Illegal opcode, then reset during a stall
    step(1'b1, 1'b1, 16'hE000, 1'b0, 16'h0, 16'h0);
    chk("illegal_set", {ill, v}, {1'b1, 1'b0});
    step(1'b1, 1'b1, 16'h1650, 1'b1, 16'd1, 16'd2);
    step(1'b0, 1'b1, 16'h1650, 1'b1, 16'd1, 16'd2);
    chk("rst_stall_regs", {v, cmd, dest, a, b, sd, mw, mux, wb}, 64'h0);
    chk("rst_stall_stat", {ill, cnt, ill_w, cnt_w}, 64'h0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd10;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), ins,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
